// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin arbiter for two APB requesters onto one shared bus. A zero-wait transfer takes 4 cycles, and the requester sees pready one cycle after s_pready.
// Defining APB_ARB_TIMEOUT_EN adds an ACCESS watchdog that ends a stuck transfer with pslverr=1 and prdata=0.
module apb_arbiter #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      m0_psel,
   input  logic                      m0_penable,
   input  logic                      m0_pwrite,
   input  logic [APB_ADDR_WIDTH-1:0] m0_paddr,
   input  logic [31:0]               m0_pwdata,
   output logic [31:0]               m0_prdata,
   output logic                      m0_pready,
   output logic                      m0_pslverr,
   input  logic                      m1_psel,
   input  logic                      m1_penable,
   input  logic                      m1_pwrite,
   input  logic [APB_ADDR_WIDTH-1:0] m1_paddr,
   input  logic [31:0]               m1_pwdata,
   output logic [31:0]               m1_prdata,
   output logic                      m1_pready,
   output logic                      m1_pslverr,
   output logic                      s_psel,
   output logic                      s_penable,
   output logic                      s_pwrite,
   output logic [APB_ADDR_WIDTH-1:0] s_paddr,
   output logic [31:0]               s_pwdata,
   input  logic [31:0]               s_prdata,
   input  logic                      s_pready,
   input  logic                      s_pslverr,
   output logic [1:0]                grant_o
);
   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [1:0]                r_gnt;
   logic                      r_last;
   logic                      r_pwrite;
   logic [APB_ADDR_WIDTH-1:0] r_paddr;
   logic [31:0]               r_pwdata;
   logic [31:0]               r_prdata;
   logic                      r_pslverr;
   logic                      w_req;
   logic                      w_pick1;
   logic                      w_timeout;
   logic                      w_unused;

   assign w_req   = m0_psel | m1_psel;
   // On a tie, grant the requester that was not served last (r_last=1 means m1 was served last).
   assign w_pick1 = m1_psel & (~m0_psel | ~r_last);

`ifdef APB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tcnt;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)                 r_tcnt <= '0;
      else if (r_state == ST_SETUP)  r_tcnt <= '0;
      else if (r_state == ST_ACCESS) r_tcnt <= r_tcnt + 1'b1;
   end

   assign w_timeout = (r_state == ST_ACCESS) && !s_pready && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
   assign w_unused  = &{1'b0, m0_penable, m1_penable};
`else
   assign w_timeout = 1'b0;
   assign w_unused  = &{1'b0, m0_penable, m1_penable, TIMEOUT_CYCLES[0]};
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      s_psel      = 1'b0;
      s_penable   = 1'b0;
      m0_pready   = 1'b0;
      m1_pready   = 1'b0;
      m0_pslverr  = 1'b0;
      m1_pslverr  = 1'b0;
      m0_prdata   = 32'h0;
      m1_prdata   = 32'h0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) w_state_nxt = ST_SETUP;
         end
         ST_SETUP: begin
            s_psel      = 1'b1;
            w_state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            s_psel    = 1'b1;
            s_penable = 1'b1;
            if (s_pready || w_timeout) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            m0_pready   = r_gnt[0];
            m1_pready   = r_gnt[1];
            m0_pslverr  = r_gnt[0] & r_pslverr;
            m1_pslverr  = r_gnt[1] & r_pslverr;
            m0_prdata   = r_gnt[0] ? r_prdata : 32'h0;
            m1_prdata   = r_gnt[1] ? r_prdata : 32'h0;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_gnt     <= 2'b00;
         r_last    <= 1'b1;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= 32'h0;
         r_prdata  <= 32'h0;
         r_pslverr <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_gnt    <= w_pick1 ? 2'b10 : 2'b01;
                  r_pwrite <= w_pick1 ? m1_pwrite : m0_pwrite;
                  r_paddr  <= w_pick1 ? m1_paddr  : m0_paddr;
                  r_pwdata <= w_pick1 ? m1_pwdata : m0_pwdata;
               end
            end
            ST_ACCESS: begin
               if (w_timeout) begin
                  r_prdata  <= 32'h0;
                  r_pslverr <= 1'b1;
               end else if (s_pready) begin
                  r_prdata  <= s_prdata;
                  r_pslverr <= s_pslverr;
               end
            end
            ST_DONE: begin
               r_last <= r_gnt[1];
               r_gnt  <= 2'b00;
            end
            default: ;
         endcase
      end
   end

   assign s_pwrite = r_pwrite;
   assign s_paddr  = r_paddr;
   assign s_pwdata = r_pwdata;
   assign grant_o  = r_gnt;
endmodule
